rr_mux_reg: RTL and testbench
=============================

RR_MUX_REG -- requirements
Module: rr_mux_reg

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel (>=1).
REQ-002 Parameter NUM_IN, default 4, number of input channels (>=2).
REQ-003 Parameter MODE, default MODE_RR, selection mode: MODE_SEL (external index) or MODE_RR (round-robin).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  in  NUM_IN  per-channel valid.
REQ-008 in_ready  out  NUM_IN  per-channel ready, one-hot or zero.
REQ-009 sel  in  SELW = max(1, clog2(NUM_IN))  channel index; used only in MODE_SEL.
REQ-010 out_data  out  WIDTH  registered selected data.
REQ-011 out_src  out  SELW  index of the channel that supplied out_data.
REQ-012 out_valid  out  1  output register holds a word.
REQ-013 out_ready  in  1  downstream accepts the word.

Function
REQ-014 Transfer rule: a transfer occurs on any port whose valid and ready are both high at a rising edge.
REQ-015 Output register is "loadable" when out_valid=0 or out_ready=1; in_ready is all-zero when not loadable.
REQ-016 MODE_SEL: when loadable, in_ready[sel]=1 and all other bits are 0; sel >= NUM_IN gives in_ready all-zero.
REQ-017 MODE_RR: when loadable, grant goes to the first valid channel at or after pointer ptr, searching upward with wrap from NUM_IN-1 to 0; in_ready = that one-hot grant.
REQ-018 in_ready is combinational from in_valid, sel, ptr, out_valid and out_ready; it never depends on in_data.
REQ-019 On an input transfer from channel g: out_data <= in_data[g], out_src <= g, out_valid <= 1 at the same edge.
REQ-020 Latency: one cycle from input transfer to out_valid.
REQ-021 On an output transfer with no simultaneous input transfer, out_valid <= 0; out_data and out_src hold.
REQ-022 A simultaneous output transfer and input transfer replaces the word, keeping out_valid=1 and sustaining 1 word/cycle.
REQ-023 When out_valid=1 and out_ready=0, out_data, out_src and out_valid are stable.
REQ-024 MODE_RR: after a transfer from channel g, ptr <= (g+1) mod NUM_IN, including wrap at g=NUM_IN-1.
REQ-025 MODE_RR: ptr holds when no input transfer occurs, including when no channel is valid or the output stalls.
REQ-026 MODE_SEL: ptr is unused and holds 0.
REQ-027 A channel that is not granted sees no side effect; its valid may stay high indefinitely.
REQ-028 Fairness: with all channels continuously valid and out_ready=1, MODE_RR grants 0,1,...,NUM_IN-1,0,... in that order.
REQ-029 Non-power-of-two NUM_IN: ptr and out_src never take values >= NUM_IN.

Reset
REQ-030 While rst_n=0, regardless of clk: out_valid=0, out_data=0, out_src=0, ptr=0.
REQ-031 Reset asserted mid-stream discards any held word without an output transfer; in_ready reflects the empty register immediately after release.
REQ-032 Reset is released synchronously externally; the block has no reset synchronizer.

Structure
REQ-033 Shared package mux_pkg holds mode constants MODE_SEL and MODE_RR and the SELW width function.
REQ-034 The round-robin grant logic (in: valid vector, ptr; out: one-hot grant, grant index, any-grant) is the sub-module rr_arbiter, parametrised by NUM_IN.
REQ-035 The data selection is a combinational indexed select into a single WIDTH-bit register; there is no other storage.

Verification
REQ-036 Reset check: rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=4'b0000 during reset; in_ready=4'b0001 the first cycle after release (MODE_RR).
REQ-037 RR fairness: NUM_IN=4, all valid, data=ch index*0x11111111, out_ready=1 -> out_src sequence 0,1,2,3,0, out_data 0x00000000,0x11111111,... one word per cycle.
REQ-038 Back-pressure: out_valid=1, out_ready=0 for 5 cycles -> in_ready=0, out_data/out_src/ptr unchanged; on out_ready=1 the next grant follows the previous one.
REQ-039 Sparse RR with wrap: ptr=3, only ch1 valid -> grant ch1, ptr becomes 2; then only ch3 and ch0 valid -> grant ch3, then ch0.
REQ-040 MODE_SEL: sel=2, in_valid=4'b0101 -> ch2 transfers and out_src=2; sel=1 with ch1 invalid -> no transfer, out_valid falls after drain.
REQ-041 NUM_IN=3, WIDTH=8, all valid -> out_src cycles 0,1,2,0 and never reaches 3; async reset asserted mid-stream -> out_valid drops without a clock edge.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the registered channel multiplexer family.
// Holds the selection-mode constants and the index-width helper so the
// top level and the arbiter agree on the width of channel indices.
package mux_pkg;

    // Selection modes for rr_mux_reg.
    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Width of a channel index; a single channel pair still needs one bit.
    function automatic int selWidth(input int numIn);
        if (numIn <= 2) begin
            return 1;
        end
        return $clog2(numIn);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant logic.
// Searches upward from the pointer, wrapping from NUM_IN-1 back to 0,
// and grants the first valid channel. Purely combinational; the pointer
// itself lives in the parent, which advances it after each transfer.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SELW   = selWidth(NUM_IN)
) (
    input  logic [NUM_IN-1:0] i_valid,
    input  logic [SELW-1:0]   i_ptr,
    output logic [NUM_IN-1:0] o_grant,
    output logic [SELW-1:0]   o_grantIdx,
    output logic              o_anyGrant
);

    int              w_idxInt;
    logic [SELW-1:0] w_idx;

    // Walk the channels in priority order starting at the pointer; first valid wins.
    always_comb begin
        o_grant    = '0;
        o_grantIdx = '0;
        o_anyGrant = 1'b0;
        w_idxInt   = 0;
        w_idx      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_idxInt = int'(i_ptr) + k;
            if (w_idxInt >= NUM_IN) begin
                w_idxInt = w_idxInt - NUM_IN;
            end
            w_idx = SELW'(w_idxInt);
            if (!o_anyGrant && i_valid[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grantIdx     = w_idx;
                o_anyGrant     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// Registered N:1 channel multiplexer with valid/ready handshakes.
// Picks one input channel per cycle, either by an external index (MODE_SEL)
// or by a round-robin pointer (MODE_RR), and loads the chosen word into a
// single output register. The register accepts a new word whenever it is
// empty or being drained in the same cycle, so it sustains one word/cycle.
module rr_mux_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    parameter  int MODE   = MODE_RR,
    localparam int SELW   = selWidth(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SELW-1:0]         sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  r_outData;
    logic [SELW-1:0]   r_outSrc;
    logic              r_outValid;
    logic [SELW-1:0]   r_ptr;

    logic              w_loadable;
    logic              w_xfer;
    logic [NUM_IN-1:0] w_request;
    logic [SELW-1:0]   w_grantIdx;
    logic [SELW-1:0]   w_ptrNext;
    logic [WIDTH-1:0]  w_selData;

    // The register can take a word when empty or when its word leaves this
    // cycle; holding reset also blocks loading so in_ready reads zero.
    assign w_loadable = rst_n & (~r_outValid | out_ready);
    assign in_ready   = w_loadable ? w_request : '0;

    generate
        if (MODE == MODE_RR) begin : gRr
            logic w_anyGrant;
            logic w_unusedSel;

            rr_arbiter #(
                .NUM_IN     (NUM_IN)
            ) uArbiter (
                .i_valid    (in_valid),
                .i_ptr      (r_ptr),
                .o_grant    (w_request),
                .o_grantIdx (w_grantIdx),
                .o_anyGrant (w_anyGrant)
            );

            // The arbiter only grants valid channels, so any grant is a transfer.
            assign w_xfer      = w_loadable & w_anyGrant;
            assign w_ptrNext   = (int'(w_grantIdx) == NUM_IN - 1) ? '0 : w_grantIdx + SELW'(1);
            assign w_unusedSel = ^sel;
        end else begin : gSel
            logic w_unusedPtr;

            // Offer ready to the indexed channel only; an out-of-range index matches nothing.
            always_comb begin
                w_request = '0;
                for (int i = 0; i < NUM_IN; i++) begin
                    w_request[i] = (sel == SELW'(i));
                end
            end

            assign w_grantIdx  = sel;
            assign w_xfer      = |(in_ready & in_valid);
            assign w_ptrNext   = '0;
            assign w_unusedPtr = ^r_ptr;
        end
    endgenerate

    // Pick the granted channel's word out of the flat input bus.
    always_comb begin
        w_selData = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grantIdx == SELW'(i)) begin
                w_selData = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer: load on input transfer, empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outData  <= '0;
            r_outSrc   <= '0;
            r_outValid <= 1'b0;
            r_ptr      <= '0;
        end else if (w_xfer) begin
            r_outData  <= w_selData;
            r_outSrc   <= w_grantIdx;
            r_outValid <= 1'b1;
            r_ptr      <= w_ptrNext;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_data  = r_outData;
    assign out_src   = r_outSrc;
    assign out_valid = r_outValid;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Testbench for rr_mux_reg.
// Three instances share clock and reset: 4-channel round-robin (A),
// 4-channel external select (B) and 3-channel 8-bit round-robin (C).
// A transaction-level model tracks each instance's held word and pointer.
module tb_rr_mux_reg;
    import mux_pkg::*;

    logic clk;
    logic rst_n;
    int   testsRun    = 0;
    int   testsFailed = 0;

    logic [127:0] aData;  logic [3:0] aValid, aReady; logic [1:0] aSel, aOutSrc;
    logic [31:0]  aOutData; logic aOutValid, aOutReady;
    logic [127:0] bData;  logic [3:0] bValid, bReady; logic [1:0] bSel, bOutSrc;
    logic [31:0]  bOutData; logic bOutValid, bOutReady;
    logic [23:0]  cData;  logic [2:0] cValid, cReady; logic [1:0] cSel, cOutSrc;
    logic [7:0]   cOutData; logic cOutValid, cOutReady;

    bit mAValid, mBValid, mCValid;
    logic [31:0] mAData, mBData;
    logic [7:0]  mCData;
    int mASrc, mBSrc, mCSrc, mAPtr, mCPtr;

    rr_mux_reg #(.WIDTH(32), .NUM_IN(4), .MODE(MODE_RR)) dutA (
        .clk(clk), .rst_n(rst_n), .in_data(aData), .in_valid(aValid), .in_ready(aReady),
        .sel(aSel), .out_data(aOutData), .out_src(aOutSrc), .out_valid(aOutValid), .out_ready(aOutReady));
    rr_mux_reg #(.WIDTH(32), .NUM_IN(4), .MODE(MODE_SEL)) dutB (
        .clk(clk), .rst_n(rst_n), .in_data(bData), .in_valid(bValid), .in_ready(bReady),
        .sel(bSel), .out_data(bOutData), .out_src(bOutSrc), .out_valid(bOutValid), .out_ready(bOutReady));
    rr_mux_reg #(.WIDTH(8), .NUM_IN(3), .MODE(MODE_RR)) dutC (
        .clk(clk), .rst_n(rst_n), .in_data(cData), .in_valid(cValid), .in_ready(cReady),
        .sel(cSel), .out_data(cOutData), .out_src(cOutSrc), .out_valid(cOutValid), .out_ready(cOutReady));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Round-robin rule: first valid channel at or after ptr, with wrap; -1 if none.
    function automatic int rrPick(input logic [3:0] valid, input int ptr, input int n, input bit loadable);
        int idx;
        if (!loadable) return -1;
        for (int k = 0; k < n; k++) begin
            idx = (ptr + k) % n;
            if (valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] oneHot(input int g);
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    task automatic modelReset();
        mAValid = 0; mBValid = 0; mCValid = 0;
        mAData = '0; mBData = '0; mCData = '0;
        mASrc = 0; mBSrc = 0; mCSrc = 0; mAPtr = 0; mCPtr = 0;
    endtask

    // One clock edge; the model consumes the inputs that were present at the edge.
    task automatic tick();
        int gA, gB, gC;
        bit live;
        live = (rst_n === 1'b1);
        gA = rrPick(aValid, mAPtr, 4, !mAValid || aOutReady);
        gB = ((!mBValid || bOutReady) && bValid[bSel]) ? int'(bSel) : -1;
        gC = rrPick({1'b0, cValid}, mCPtr, 3, !mCValid || cOutReady);
        @(posedge clk);
        #1;
        if (!live) begin
            modelReset();
            return;
        end
        if (gA >= 0) begin
            mAData = aData[gA*32 +: 32]; mASrc = gA; mAValid = 1; mAPtr = (gA + 1) % 4;
        end else if (mAValid && aOutReady) mAValid = 0;
        if (gB >= 0) begin
            mBData = bData[gB*32 +: 32]; mBSrc = gB; mBValid = 1;
        end else if (mBValid && bOutReady) mBValid = 0;
        if (gC >= 0) begin
            mCData = cData[gC*8 +: 8]; mCSrc = gC; mCValid = 1; mCPtr = (gC + 1) % 3;
        end else if (mCValid && cOutReady) mCValid = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        aValid = 4'hF; aOutReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if (aOutValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", aOutValid); end
        testsRun++;
        if (aOutData !== 32'h0 || aOutSrc !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_out_data: got %h/%0d expected 0/0", aOutData, aOutSrc); end
        testsRun++;
        if (aReady !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b expected 0000", aReady); end
        rst_n = 1'b1;
        modelReset();
        #1;
        testsRun++;
        if (aReady !== 4'b0001) begin testsFailed++; $display("[TB] FAIL release_in_ready: got %b expected 0001", aReady); end
    endtask

    task automatic test_rr_fairness();
        for (int i = 0; i < 4; i++) aData[i*32 +: 32] = i * 32'h11111111;
        aValid = 4'hF; aOutReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            testsRun++;
            if (aReady !== oneHot(k % 4)) begin testsFailed++; $display("[TB] FAIL fair_ready[%0d]: got %b expected %b", k, aReady, oneHot(k % 4)); end
            tick();
            testsRun++;
            if (aOutValid !== 1'b1 || aOutSrc !== 2'(k % 4) || aOutData !== (k % 4) * 32'h11111111) begin
                testsFailed++;
                $display("[TB] FAIL fair_out[%0d]: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
                         k, aOutValid, aOutSrc, aOutData, k % 4, (k % 4) * 32'h11111111);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] savedData;
        logic [1:0]  savedSrc;
        savedData = aOutData; savedSrc = aOutSrc;
        aOutReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            testsRun++;
            if (aReady !== 4'b0000 || aOutValid !== 1'b1 || aOutData !== savedData || aOutSrc !== savedSrc) begin
                testsFailed++;
                $display("[TB] FAIL stall[%0d]: got ready=%b v=%b src=%0d data=%h expected ready=0000 v=1 src=%0d data=%h",
                         k, aReady, aOutValid, aOutSrc, aOutData, savedSrc, savedData);
            end
            tick();
        end
        aOutReady = 1'b1;
        #1;
        testsRun++;
        if (aReady !== oneHot((int'(savedSrc) + 1) % 4)) begin testsFailed++; $display("[TB] FAIL stall_resume_ready: got %b expected %b", aReady, oneHot((int'(savedSrc) + 1) % 4)); end
        tick();
        testsRun++;
        if (aOutSrc !== 2'((int'(savedSrc) + 1) % 4) || aOutData !== mAData) begin
            testsFailed++;
            $display("[TB] FAIL stall_resume_out: got src=%0d data=%h expected src=%0d data=%h", aOutSrc, aOutData, (int'(savedSrc) + 1) % 4, mAData);
        end
    endtask

    task automatic test_sparse_wrap();
        aValid = 4'b0100;
        tick();
        testsRun++;
        if (aOutSrc !== 2'd2) begin testsFailed++; $display("[TB] FAIL sparse_setup: got src=%0d expected 2", aOutSrc); end
        aValid = 4'b0010;
        #1;
        testsRun++;
        if (aReady !== 4'b0010) begin testsFailed++; $display("[TB] FAIL sparse_ch1_ready: got %b expected 0010", aReady); end
        tick();
        aValid = 4'b1001;
        #1;
        testsRun++;
        if (aReady !== 4'b1000) begin testsFailed++; $display("[TB] FAIL sparse_ch3_ready: got %b expected 1000", aReady); end
        tick();
        testsRun++;
        if (aOutSrc !== 2'd3) begin testsFailed++; $display("[TB] FAIL sparse_ch3_src: got %0d expected 3", aOutSrc); end
        #1;
        testsRun++;
        if (aReady !== 4'b0001) begin testsFailed++; $display("[TB] FAIL sparse_ch0_ready: got %b expected 0001", aReady); end
        tick();
        testsRun++;
        if (aOutSrc !== 2'd0) begin testsFailed++; $display("[TB] FAIL sparse_ch0_src: got %0d expected 0", aOutSrc); end
        aValid = 4'b0000;
        tick();
        testsRun++;
        if (aOutValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL sparse_drain: got v=%b expected 0", aOutValid); end
    endtask

    task automatic test_sel_mode();
        logic [31:0] ch2Word;
        bData = {$urandom, $urandom, $urandom, $urandom};
        ch2Word = bData[64 +: 32];
        bSel = 2'd2; bValid = 4'b0101; bOutReady = 1'b1;
        #1;
        testsRun++;
        if (bReady !== 4'b0100) begin testsFailed++; $display("[TB] FAIL sel2_ready: got %b expected 0100", bReady); end
        tick();
        testsRun++;
        if (bOutValid !== 1'b1 || bOutSrc !== 2'd2 || bOutData !== ch2Word) begin
            testsFailed++;
            $display("[TB] FAIL sel2_out: got v=%b src=%0d data=%h expected v=1 src=2 data=%h", bOutValid, bOutSrc, bOutData, ch2Word);
        end
        bSel = 2'd1;
        #1;
        testsRun++;
        if (bReady !== 4'b0010) begin testsFailed++; $display("[TB] FAIL sel1_ready: got %b expected 0010", bReady); end
        tick();
        testsRun++;
        if (bOutValid !== 1'b0 || bOutSrc !== 2'd2 || bOutData !== ch2Word) begin
            testsFailed++;
            $display("[TB] FAIL sel1_drain: got v=%b src=%0d data=%h expected v=0 src=2 data=%h", bOutValid, bOutSrc, bOutData, ch2Word);
        end
        bValid = 4'b0000;
    endtask

    task automatic test_random();
        logic [3:0] expA, expB, expC;
        for (int n = 0; n < 300; n++) begin
            aData = {$urandom, $urandom, $urandom, $urandom};
            bData = {$urandom, $urandom, $urandom, $urandom};
            cData = 24'($urandom);
            aValid = 4'($urandom); bValid = 4'($urandom); cValid = 3'($urandom);
            bSel = 2'($urandom);
            aOutReady = ($urandom_range(3) != 0); bOutReady = ($urandom_range(3) != 0); cOutReady = ($urandom_range(3) != 0);
            #1;
            expA = oneHot(rrPick(aValid, mAPtr, 4, !mAValid || aOutReady));
            expB = (!mBValid || bOutReady) ? oneHot(int'(bSel)) : 4'b0000;
            expC = oneHot(rrPick({1'b0, cValid}, mCPtr, 3, !mCValid || cOutReady));
            testsRun++;
            if (aReady !== expA || aOutValid !== mAValid || aOutData !== mAData || aOutSrc !== 2'(mASrc)) begin
                testsFailed++;
                $display("[TB] FAIL rand_A[%0d]: got r=%b v=%b s=%0d d=%h expected r=%b v=%b s=%0d d=%h",
                         n, aReady, aOutValid, aOutSrc, aOutData, expA, mAValid, mASrc, mAData);
            end
            testsRun++;
            if (bReady !== expB || bOutValid !== mBValid || bOutData !== mBData || bOutSrc !== 2'(mBSrc)) begin
                testsFailed++;
                $display("[TB] FAIL rand_B[%0d]: got r=%b v=%b s=%0d d=%h expected r=%b v=%b s=%0d d=%h",
                         n, bReady, bOutValid, bOutSrc, bOutData, expB, mBValid, mBSrc, mBData);
            end
            testsRun++;
            if (cReady !== expC[2:0] || cOutValid !== mCValid || cOutData !== mCData || cOutSrc !== 2'(mCSrc) || cOutSrc === 2'd3) begin
                testsFailed++;
                $display("[TB] FAIL rand_C[%0d]: got r=%b v=%b s=%0d d=%h expected r=%b v=%b s=%0d d=%h",
                         n, cReady, cOutValid, cOutSrc, cOutData, expC[2:0], mCValid, mCSrc, mCData);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        aValid = 4'hF; cValid = 3'b111; bValid = 4'b0000;
        aOutReady = 1'b1; cOutReady = 1'b1;
        tick();
        tick();
        testsRun++;
        if (aOutValid !== 1'b1 || cOutValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream_before_reset: got A=%b C=%b expected 1/1", aOutValid, cOutValid); end
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (aOutValid !== 1'b0 || cOutValid !== 1'b0 || aOutData !== 32'h0 || aReady !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got A.v=%b C.v=%b A.d=%h A.r=%b expected 0/0/0/0000", aOutValid, cOutValid, aOutData, aReady);
        end
        @(posedge clk);
        #1;
        cValid = 3'b000;
        rst_n = 1'b1;
        modelReset();
        #1;
        testsRun++;
        if (aReady !== 4'b0001) begin testsFailed++; $display("[TB] FAIL async_release_ready: got %b expected 0001", aReady); end
    endtask

    task automatic test_num3();
        cData = {8'hC2, 8'hB1, 8'hA0};
        cValid = 3'b111; cOutReady = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            testsRun++;
            if (cReady !== 3'(1 << (k % 3))) begin testsFailed++; $display("[TB] FAIL n3_ready[%0d]: got %b expected %b", k, cReady, 3'(1 << (k % 3))); end
            tick();
            testsRun++;
            if (cOutSrc !== 2'(k % 3) || cOutData !== 8'(8'hA0 + (k % 3) * 8'h11)) begin
                testsFailed++;
                $display("[TB] FAIL n3_out[%0d]: got src=%0d data=%h expected src=%0d data=%h", k, cOutSrc, cOutData, k % 3, 8'(8'hA0 + (k % 3) * 8'h11));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        aData = '0; aValid = '0; aSel = '0; aOutReady = 1'b0;
        bData = '0; bValid = '0; bSel = '0; bOutReady = 1'b0;
        cData = '0; cValid = '0; cSel = '0; cOutReady = 1'b0;
        modelReset();
        test_reset();
        test_rr_fairness();
        test_back_pressure();
        test_sparse_wrap();
        test_sel_mode();
        test_random();
        test_async_reset();
        test_num3();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
